// File: rtl/encoder_32_arb.sv
// Sequential 32-to-5 request encoder: latches request pulses and hands them out one at a time over a valid/ack handshake.
// Define ENCODER_32_ROUND_ROBIN_EN for round-robin selection; fixed lowest-index priority otherwise.
module encoder_32_arb (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] req_i,
    input  logic        ack_i,
    output logic [4:0]  index_o,
    output logic        valid_o,
    output logic [31:0] pending_o
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [31:0] pending_q, pending_d;
    logic [4:0]  index_q, index_d;
    logic [4:0]  last_q, last_d;
    logic [31:0] idx_onehot;
    logic [31:0] clr;
    logic [31:0] survivors;
    logic [4:0]  start_idle;
    logic [4:0]  start_ack;
    logic        serve;

    // First set bit of src at or above start, wrapping 31 -> 0.
    function automatic logic [4:0] select_fn(input logic [31:0] src, input logic [4:0] start);
        logic [63:0] dbl;
        logic [31:0] rot;
        logic [4:0]  off;
        dbl = {src, src} >> start;
        rot = dbl[31:0];
        off = 5'd0;
        for (int k = 31; k >= 0; k--) begin
            if (rot[k]) off = 5'(k);
        end
        return start + off;
    endfunction

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_onehot
            assign idx_onehot[gi] = (index_q == 5'(gi));
        end
    endgenerate

`ifdef ENCODER_32_ROUND_ROBIN_EN
    assign start_idle = last_q + 5'd1;
    // On ack the served index becomes the new pointer, so search from just past it.
    assign start_ack  = index_q + 5'd1;
`else
    logic unused_last;
    assign start_idle  = 5'd0;
    assign start_ack   = 5'd0;
    assign unused_last = ^last_q;
`endif

    assign serve     = (state_q == GRANT) && ack_i;
    assign clr       = serve ? idx_onehot : 32'h0;
    assign survivors = pending_q & ~idx_onehot;
    // A request arriving on the bit being cleared wins, so the source re-pends.
    assign pending_d = (pending_q & ~clr) | req_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            pending_q <= 32'h0;
            index_q   <= 5'd0;
            last_q    <= 5'd31;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            index_q   <= index_d;
            last_q    <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (pending_q != 32'h0) begin
                    index_d = select_fn(pending_q, start_idle);
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (ack_i) begin
                    last_d = index_q;
                    if (survivors != 32'h0) begin
                        index_d = select_fn(survivors, start_ack);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    always_comb begin
        valid_o   = (state_q == GRANT);
        index_o   = index_q;
        pending_o = pending_q;
    end

endmodule
